// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2) polynomial divider.
package gf2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned dw_of(int unsigned w);
        return 2 * w - 1;
    endfunction

    function automatic int unsigned cnt_w_of(int unsigned w);
        return $clog2(dw_of(w));
    endfunction

endpackage

// File: rtl/gf2_poly_div_seq_if.sv
// Operand/result handshake bundle for gf2_poly_div_seq.
interface gf2_poly_div_seq_if
    import gf2_pkg::*;
#(
    parameter int unsigned W = 8
);
    localparam int unsigned DW = dw_of(W);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/gf2_msb_index.sv
// Priority encoder: index of the highest set bit plus an all-zero flag.
module gf2_msb_index #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          zero_c
);
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (vec[i]) idx_c = IW'(i);
        end
    end

    assign zero_c = ~|vec;
endmodule

// File: rtl/gf2_poly_div_seq.sv
// Bit-serial carry-less divider: one dividend bit per cycle, MSB first,
// producing quotient and remainder over GF(2).
module gf2_poly_div_seq
    import gf2_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gf2_poly_div_seq_if.slave bus
);
    localparam int unsigned DW = dw_of(W);
    localparam int unsigned CW = cnt_w_of(W);
    localparam int unsigned IW = $clog2(W);

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [W-1:0]  d_q, d_d;
    logic [IW-1:0] deg_q, deg_d;
    logic [W-1:0]  r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_d;
    logic [W-1:0]  rem_d;
    logic          dbz_d;

    logic [IW-1:0] div_idx_c;
    logic          div_zero_c;
    logic [W-1:0]  t_c;
    logic          hit_c;
    logic [W-1:0]  step_r_c;

    gf2_msb_index #(.W(W), .IW(IW)) u_msb (
        .vec    (bus.divisor),
        .idx_c  (div_idx_c),
        .zero_c (div_zero_c)
    );

    // Bring down the next dividend bit; subtract the divisor when the leading term is set.
    assign t_c      = {r_q[W-2:0], a_q[DW-1]};
    assign hit_c    = t_c[deg_q];
    assign step_r_c = hit_c ? (t_c ^ d_q) : t_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        deg_d   = deg_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = bus.quotient;
        rem_d   = bus.remainder;
        dbz_d   = bus.div_by_zero;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.dividend;
                    d_d   = bus.divisor;
                    deg_d = div_idx_c;
                    r_d   = '0;
                    q_d   = '0;
                    cnt_d = CW'(DW - 1);
                    dbz_d = div_zero_c;
                    if (div_zero_c) begin
                        quo_d   = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                a_d = {a_q[DW-2:0], 1'b0};
                r_d = step_r_c;
                q_d = {q_q[DW-2:0], hit_c};
                if (cnt_q == '0) begin
                    quo_d   = {q_q[DW-2:0], hit_c};
                    rem_d   = step_r_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            a_q             <= '0;
            d_q             <= '0;
            deg_q           <= '0;
            r_q             <= '0;
            q_q             <= '0;
            cnt_q           <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            d_q             <= d_d;
            deg_q           <= deg_d;
            r_q             <= r_d;
            q_q             <= q_d;
            cnt_q           <= cnt_d;
            bus.in_ready    <= (state_d == IDLE);
            bus.out_valid   <= (state_d == DONE);
            bus.quotient    <= quo_d;
            bus.remainder   <= rem_d;
            bus.div_by_zero <= dbz_d;
        end
    end
endmodule
